// File: rtl/sipo_frame_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sipo_frame_capture                                           |
// | Brief   : Serial-in/parallel-out frame capture with a one-word valid/  |
// |           ready holding register and a sticky overrun flag.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sipo_frame_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             RE,
    input  logic             SIN,
    input  logic             SEN,
    output logic [WIDTH-1:0] POUT,
    output logic             PVALID,
    input  logic             PREADY,
    output logic             BUSY,
    output logic             OVF
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    hold_state_t      r_state;
    hold_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_word;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_pout;
    logic             r_busy;
    logic             r_ovf;
    logic             w_complete;
    logic             w_load;
    logic             w_ovf_set;

    // Shift register contents with the current SIN already included.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word = {r_shift[WIDTH-2:0], SIN};
        end else begin : g_lsb_first
            assign w_word = {SIN, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_complete = SEN && (r_cnt == C_CNT_LAST);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (SEN) begin
            w_cnt_nxt = w_complete ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge C) begin
        if (RE) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (SEN) begin
                r_shift <= w_word;
            end
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    always_ff @(posedge C) begin
        if (RE) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A full register with no taker drops the incoming word and flags overrun.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_complete) begin
                    w_state_nxt = FULL;
                    w_load      = 1'b1;
                end
            end
            FULL: begin
                if (PREADY) begin
                    w_load      = w_complete;
                    w_state_nxt = w_complete ? FULL : EMPTY;
                end else if (w_complete) begin
                    w_ovf_set = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge C) begin
        if (RE) begin
            r_pout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load) begin
                r_pout <= w_word;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign POUT   = r_pout;
    assign PVALID = (r_state == FULL);
    assign BUSY   = r_busy;
    assign OVF    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sipo_frame_capture                                        |
// | Brief   : Directed self-checking bench; MSB-first and LSB-first        |
// |           instances share one stimulus stream.                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sipo_frame_capture;

    logic       clk;
    logic       re;
    logic       sin;
    logic       sen;
    logic       pready;
    logic [7:0] pout_m;
    logic [7:0] pout_l;
    logic       pvalid_m;
    logic       pvalid_l;
    logic       busy_m;
    logic       busy_l;
    logic       ovf_m;
    logic       ovf_l;

    int checks = 0;
    int errors = 0;

    sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .C(clk), .RE(re), .SIN(sin), .SEN(sen),
        .POUT(pout_m), .PVALID(pvalid_m), .PREADY(pready),
        .BUSY(busy_m), .OVF(ovf_m)
    );

    sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .C(clk), .RE(re), .SIN(sin), .SEN(sen),
        .POUT(pout_l), .PVALID(pvalid_l), .PREADY(pready),
        .BUSY(busy_l), .OVF(ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        sen = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        sen = 1'b0;
        sin = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends v[7] first, so u_msb assembles v and u_lsb assembles v bit-reversed.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        re  = 1'b1;
        tick();
        re  = 1'b0;
    endtask

    initial begin
        re = 1'b0; sin = 1'b0; sen = 1'b0; pready = 1'b1;
        do_reset();
        chk("rst_pout_m", pout_m, 8'h00);
        chk("rst_pvalid_m", pvalid_m, 1'b0);
        chk("rst_busy_m", busy_m, 1'b0);
        chk("rst_ovf_m", ovf_m, 1'b0);
        chk("rst_pout_l", pout_l, 8'h00);

        // T1/T2: continuous frame, consumer ready
        pready = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hB2 >> i));
        chk("t1_busy_mid", busy_m, 1'b1);
        chk("t1_pvalid_early", pvalid_m, 1'b0);
        send_bit(1'b0);
        chk("t1_pout", pout_m, 8'hB2);
        chk("t1_pvalid", pvalid_m, 1'b1);
        chk("t1_busy_end", busy_m, 1'b0);
        chk("t2_pout", pout_l, 8'h4D);
        chk("t2_pvalid", pvalid_l, 1'b1);
        idle(1);
        chk("t1_pvalid_drop", pvalid_m, 1'b0);
        chk("t1_pout_hold", pout_m, 8'hB2);

        // T3: 3-cycle enable gap between bits 4 and 5
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t3_busy_gap", busy_m, 1'b1);
        end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        chk("t3_pvalid_early", pvalid_m, 1'b0);
        send_bit(1'b0);
        chk("t3_pout", pout_m, 8'hB2);
        chk("t3_pvalid", pvalid_m, 1'b1);
        chk("t3_busy", busy_m, 1'b0);
        idle(1);

        // T4: consumer stalled across two frames
        pready = 1'b0;
        send_byte(8'hB2);
        chk("t4_pout1", pout_m, 8'hB2);
        chk("t4_ovf_clear", ovf_m, 1'b0);
        send_byte(8'hFF);
        chk("t4_pout_kept", pout_m, 8'hB2);
        chk("t4_pout_kept_l", pout_l, 8'h4D);
        chk("t4_pvalid", pvalid_m, 1'b1);
        chk("t4_ovf_set", ovf_m, 1'b1);
        chk("t4_ovf_set_l", ovf_l, 1'b1);
        sen = 1'b0;
        pready = 1'b1;
        tick();
        chk("t4_pvalid_drop", pvalid_m, 1'b0);
        chk("t4_ovf_sticky", ovf_m, 1'b1);
        idle(2);
        chk("t4_ovf_sticky2", ovf_m, 1'b1);

        // T5: drain and completion on the same edge
        do_reset();
        chk("t5_ovf_reset", ovf_m, 1'b0);
        pready = 1'b0;
        send_byte(8'hB2);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h0F >> i));
        chk("t5_pout_pending", pout_m, 8'hB2);
        pready = 1'b1;
        send_bit(1'b1);
        chk("t5_pout", pout_m, 8'h0F);
        chk("t5_pout_l", pout_l, 8'hF0);
        chk("t5_pvalid", pvalid_m, 1'b1);
        chk("t5_ovf", ovf_m, 1'b0);
        idle(1);
        chk("t5_pvalid_drop", pvalid_m, 1'b0);

        // T6: reset mid-frame discards partial bits
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("t6_busy_pre", busy_m, 1'b1);
        re = 1'b1; sin = 1'b1; sen = 1'b1;
        tick();
        re = 1'b0;
        chk("t6_busy", busy_m, 1'b0);
        chk("t6_pout", pout_m, 8'h00);
        chk("t6_pvalid", pvalid_m, 1'b0);
        chk("t6_ovf", ovf_m, 1'b0);
        send_byte(8'hA5);
        chk("t6_pout_a5", pout_m, 8'hA5);
        chk("t6_pout_a5_l", pout_l, 8'hA5);
        chk("t6_pvalid_a5", pvalid_m, 1'b1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
